// File: rtl/pixel_stream_source.sv
// pixel_stream_source: raster frame-buffer reader (start/pause in, BRAM read port, pixel strobe with eol/frame_done out)
module pixel_stream_source #(
  parameter int WIDTH     = 8,
  parameter int ROWS      = 5,
  parameter int COLS      = 6,
  parameter int ADDR_BITS = 10,
  parameter int GAP       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [WIDTH-1:0]     mem_rd_data,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_out_done,
  output logic                 data_out_eol,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int N  = ROWS * COLS;
  localparam int GW = $clog2(GAP + 2);
  localparam int CW = $clog2(COLS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] col_q, col_d;
  logic s1_v_q, s1_v_d, s1_eol_q, s1_eol_d, s1_last_q, s1_last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic done_q, done_d, eol_q, eol_d, fd_q, fd_d;
  logic rd, last, col_end;
  always_comb begin
    rd        = state_q == RUN && gap_q == '0 && !pause;
    last      = addr_q == ADDR_BITS'(N - 1);
    col_end   = col_q == CW'(COLS - 1);
    state_d   = state_q;
    addr_d    = addr_q;
    gap_d     = gap_q;
    col_d     = col_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      addr_d  = '0;
      gap_d   = '0;
      col_d   = '0;
    end
    if (state_q == RUN) begin
      if (rd) begin
        addr_d  = last ? '0 : addr_q + 1'b1;
        gap_d   = GW'(GAP);
        col_d   = col_end ? '0 : col_q + 1'b1;
        state_d = last ? DRAIN : RUN;
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
    end
    // stage 1 empty means the final strobe is in stage 2 this cycle
    if (state_q == DRAIN && !s1_v_q) state_d = IDLE;
    s1_v_d    = rd;
    s1_eol_d  = rd && col_end;
    s1_last_d = rd && last;
    done_d    = s1_v_q;
    data_d    = s1_v_q ? mem_rd_data : data_q;
    eol_d     = s1_v_q && s1_eol_q;
    fd_d      = s1_v_q && s1_last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      gap_q     <= '0;
      col_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_eol_q  <= 1'b0;
      s1_last_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      eol_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      col_q     <= col_d;
      s1_v_q    <= s1_v_d;
      s1_eol_q  <= s1_eol_d;
      s1_last_q <= s1_last_d;
      data_q    <= data_d;
      done_q    <= done_d;
      eol_q     <= eol_d;
      fd_q      <= fd_d;
    end
  end
  assign mem_rd_en     = rd;
  assign mem_addr      = addr_q;
  assign data_out      = data_q;
  assign data_out_done = done_q;
  assign data_out_eol  = eol_q;
  assign frame_done    = fd_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_pixel_stream_source.sv
// tb_pixel_stream_source: scoreboard bench for pixel_stream_source (GAP=0 and GAP=2 instances)
module tb_pixel_stream_source;
  typedef struct {int cyc; int d; int eol; int fd;} exp_t;
  logic clk = 1'b0;
  logic rst, start_a, start_b, pause;
  logic rd_a, rd_b, done_a, done_b, eol_a, eol_b, busy_a, busy_b, fd_a, fd_b;
  logic [9:0] addr_a, addr_b;
  logic [7:0] mem_a, mem_b, data_a, data_b;
  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rd_a) mem_a <= 8'(addr_a + 10'd10);
    if (rd_b) mem_b <= 8'(addr_b + 10'd10);
  end
  pixel_stream_source #(.GAP(0)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .pause(pause),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rd_data(mem_a),
    .data_out(data_a), .data_out_done(done_a), .data_out_eol(eol_a),
    .busy(busy_a), .frame_done(fd_a));
  pixel_stream_source #(.GAP(2)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .pause(1'b0),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rd_data(mem_b),
    .data_out(data_b), .data_out_done(done_b), .data_out_eol(eol_b),
    .busy(busy_b), .frame_done(fd_b));
  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) chk("a_extra_strobe", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_strobe_cycle", cyc, ea.cyc);
        chk("a_data", int'(data_a), ea.d);
        chk("a_eol", int'(eol_a), ea.eol);
        chk("a_frame_done", int'(fd_a), ea.fd);
      end
    end else if (eol_a || fd_a) chk("a_flag_without_strobe", 1, 0);
    if (done_b) begin
      if (qb.size() == 0) chk("b_extra_strobe", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_strobe_cycle", cyc, eb.cyc);
        chk("b_data", int'(data_b), eb.d);
        chk("b_eol", int'(eol_b), eb.eol);
        chk("b_frame_done", int'(fd_b), eb.fd);
      end
    end else if (eol_b || fd_b) chk("b_flag_without_strobe", 1, 0);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask
  task automatic push_a(input int t, input int i);
    qa.push_back('{t, 10 + i, int'(i % 6 == 5), int'(i == 29)});
  endtask
  task automatic wait_empty();
    for (int k = 0; k < 300 && (qa.size() != 0 || qb.size() != 0); k++) step();
    chk("queue_drained", qa.size() + qb.size(), 0);
    for (int k = 0; k < 5; k++) step();
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_outputs"}, int'({rd_a, addr_a, data_a, done_a, eol_a, busy_a, fd_a}), 0);
  endtask
  initial begin
    int t0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pause = 1'b0;
    step(); step();
    chk_idle("reset");
    chk("reset_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    step();
    // basic frame
    t0 = cyc;
    for (int i = 0; i < 30; i++) push_a(t0 + 3 + i, i);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("basic_busy_c1", int'(busy_a), 1);
    chk("basic_first_addr", int'(addr_a), 0);
    run_to(t0 + 32); chk("basic_busy_c32", int'(busy_a), 1);
    run_to(t0 + 33); chk("basic_busy_c33", int'(busy_a), 0);
    wait_empty();
    // start while busy
    t0 = cyc;
    for (int i = 0; i < 30; i++) push_a(t0 + 3 + i, i);
    start_a = 1'b1; step(); start_a = 1'b0;
    run_to(t0 + 10); start_a = 1'b1; step(); start_a = 1'b0;
    run_to(t0 + 32); start_a = 1'b1; step(); start_a = 1'b0;
    chk("busy_start_ignored", int'(busy_a), 0);
    wait_empty();
    // pause
    t0 = cyc;
    for (int i = 0; i < 30; i++) push_a(i < 4 ? t0 + 3 + i : t0 + 7 + i, i);
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      run_to(t0 + c);
      chk("pause_pre_read", int'(rd_a), 1);
    end
    for (int c = 5; c <= 8; c++) begin
      run_to(t0 + c);
      pause = 1'b1; #1;
      chk("pause_no_read", int'(rd_a), 0);
    end
    run_to(t0 + 9);
    pause = 1'b0; #1;
    chk("pause_resume_rd", int'(rd_a), 1);
    chk("pause_resume_addr", int'(addr_a), 4);
    wait_empty();
    // reset mid-frame
    t0 = cyc;
    for (int i = 0; i < 10; i++) push_a(t0 + 3 + i, i);
    start_a = 1'b1; step(); start_a = 1'b0;
    run_to(t0 + 12); rst = 1'b1; step(); rst = 1'b0;
    chk_idle("midreset");
    chk("midreset_queue", qa.size(), 0);
    run_to(t0 + 20);
    for (int i = 0; i < 30; i++) push_a(t0 + 23 + i, i);
    start_a = 1'b1; step(); start_a = 1'b0;
    chk("restart_addr", int'(addr_a), 0);
    wait_empty();
    // back-to-back frames
    t0 = cyc;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 30; i++) push_a(t0 + 3 + 33 * f + i, i);
    start_a = 1'b1;
    run_to(t0 + 33); chk("b2b_gap_rd", int'(rd_a), 0);
    run_to(t0 + 34); chk("b2b_second_rd", int'(rd_a), 1);
    chk("b2b_second_addr", int'(addr_a), 0);
    run_to(t0 + 40); start_a = 1'b0;
    wait_empty();
    // read spacing with GAP=2
    t0 = cyc;
    for (int i = 0; i < 30; i++) qb.push_back('{t0 + 3 + 3 * i, 10 + i, int'(i % 6 == 5), int'(i == 29)});
    start_b = 1'b1; step(); start_b = 1'b0;
    run_to(t0 + 91); chk("gap_busy_end", int'(busy_b), 0);
    wait_empty();
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

Frame-buffer reader that produces the raster pixel stream consumed by the sharpening filter pipeline. It reads a ROWS×COLS grayscale frame from a synchronous-read memory (BRAM, 1-cycle read latency) and emits one pixel per `data_out_done` strobe in raster order. Strobe spacing is programmable, and the stream can be paused. It sits between the frame memory and the filter input (`data_in` / `data_in_done`).

## Interface
Parameters:
- WIDTH, 8, pixel width in bits
- ROWS, 5, frame height in lines
- COLS, 6, frame width in pixels
- ADDR_BITS, 10, memory address width; ROWS*COLS <= 2^ADDR_BITS is required
- GAP, 0, idle cycles inserted between consecutive pixel reads

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- pause  in  1  when high, no new memory read is issued
- mem_rd_en  out  1  memory read enable
- mem_addr  out  ADDR_BITS  read address, 0 to ROWS*COLS-1
- mem_rd_data  in  WIDTH  read data, valid the cycle after mem_rd_en
- data_out  out  WIDTH  pixel to the filter (`data_in`)
- data_out_done  out  1  one-cycle pixel strobe (`data_in_done`)
- data_out_eol  out  1  high with the strobe of the last pixel of each row
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse with the final pixel strobe

## Operation
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> RUN, with address counter=0 and gap counter=0.
  - start=0 -> stay in IDLE.
- RUN:
  - mem_rd_en = (gap_cnt==0) && !pause (combinational). mem_addr = address counter.
  - On each read: address counter +1, gap_cnt loaded with GAP.
  - Otherwise gap_cnt decrements while it is nonzero. It decrements regardless of pause.
  - Issuing address ROWS*COLS-1 -> DRAIN.
- DRAIN:
  - No reads are issued.
  - The state waits for the 2-stage return pipeline to empty, then goes to IDLE.
- Return pipeline:
  - Stage 1 delays the read flags (valid, eol, last) by 1 cycle to align with mem_rd_data.
  - Stage 2 registers data_out <= mem_rd_data and raises the strobes.
- data_out_eol: column counter wraps COLS-1 -> 0 on each read; the flag is set on the read where column = COLS-1.
- frame_done: asserted with the data_out_done of address ROWS*COLS-1.
- busy: high in RUN and DRAIN, low in IDLE.
- start is ignored while busy; no queuing.
- pause:
  - Blocks only read issue.
  - Reads already in flight still produce their strobes.
  - pause has no effect in IDLE or DRAIN.
- data_out holds its last value between strobes.
- Reset (including mid-frame):
  - State -> IDLE and all counters -> 0.
  - In-flight reads are discarded; no strobe is produced after reset.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, data_out=0, data_out_done=0, data_out_eol=0, busy=0, frame_done=0.
- Latency from mem_rd_en at cycle t to data_out_done at t+2.
- Frame with N=ROWS*COLS, GAP=0, pause low, start sampled at cycle 0:
  - Reads occur at cycles 1..N.
  - Strobes occur at cycles 3..N+2.
  - frame_done at cycle N+2.
  - busy is high for cycles 1..N+2.
  - The next start is accepted at cycle N+3 at the earliest.
- With GAP=g, consecutive reads (and strobes) are exactly g+1 cycles apart when pause is low.
- pause high for k cycles while gap_cnt==0 delays the next read by exactly k cycles.

## Test plan
- Basic frame:
  - Stimulus: ROWS=5, COLS=6, GAP=0, memory holds mem[a]=a+10, start pulse at cycle 0.
  - Required: 30 strobes on consecutive cycles 3..32, data 10..39.
  - Required: data_out_eol on data 15, 21, 27, 33, 39.
  - Required: frame_done at cycle 32; busy falls at cycle 33.
- Spacing:
  - Stimulus: GAP=2.
  - Required: strobes exactly 3 cycles apart; the last strobe and frame_done at cycle 3+29*3=90.
- Pause:
  - Stimulus: GAP=0; pause high for cycles 5..8.
  - Required: reads at cycles 1..4, none at 5..8, resuming at cycle 9 with address 4.
  - Required: strobes at cycles 3..6 and 11..36, no gaps in data values; frame_done at cycle 36.
- start while busy:
  - Stimulus: start pulses at cycles 10 and 32.
  - Required: both are ignored; exactly 30 strobes; one frame_done.
- Reset mid-frame:
  - Stimulus: reset at cycle 12.
  - Required: all outputs 0 from cycle 13; no strobes after that.
  - Required: a start at cycle 20 restarts from address 0 with first strobe data 10 at cycle 23.
- Back-to-back frames:
  - Stimulus: start held high.
  - Required: the second frame's first read at cycle 34; 60 strobes total; two frame_done pulses, at cycles 32 and 65.
